// File: rtl/atomrvcore_mem_wb.sv
// Memory-access / writeback stage: runs req/gnt/rvalid data-memory transactions,
// writes ALU or load results to the register file and forwards branch redirects.
module atomrvcore_mem_wb #(
    parameter int DATAWIDTH        = 32,
    parameter int REG_ADRESS_WIDTH = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [DATAWIDTH-1:0]        result_i,
    input  logic [DATAWIDTH-1:0]        address_i,
    input  logic                        DR_EN_i,
    input  logic                        DWR_EN_i,
    input  logic [DATAWIDTH-1:0]        R2_i,
    input  logic [REG_ADRESS_WIDTH-1:0] RD_i,
    input  logic                        RWR_EN_i,
    input  logic [DATAWIDTH-1:0]        PC_i,
    input  logic                        BE_i,
    output logic                        stall_o,
    output logic                        dmem_req_o,
    output logic                        dmem_we_o,
    output logic [DATAWIDTH-1:0]        dmem_addr_o,
    output logic [DATAWIDTH-1:0]        dmem_wdata_o,
    input  logic                        dmem_gnt_i,
    input  logic                        dmem_rvalid_i,
    input  logic [DATAWIDTH-1:0]        dmem_rdata_i,
    output logic                        rf_we_o,
    output logic [REG_ADRESS_WIDTH-1:0] rf_waddr_o,
    output logic [DATAWIDTH-1:0]        rf_wdata_o,
    output logic                        redirect_o,
    output logic [DATAWIDTH-1:0]        redirect_pc_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e                      state_q, state_d;
    logic                        we_q, we_d;
    logic [DATAWIDTH-1:0]        addr_q, addr_d;
    logic [DATAWIDTH-1:0]        wdata_q, wdata_d;
    logic [REG_ADRESS_WIDTH-1:0] rd_q, rd_d;
    logic                        rwr_q, rwr_d;
    logic                        rf_we_q, rf_we_d;
    logic [REG_ADRESS_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATAWIDTH-1:0]        rf_wdata_q, rf_wdata_d;
    logic                        redir_q, redir_d;
    logic [DATAWIDTH-1:0]        redir_pc_q, redir_pc_d;

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        rwr_d      = rwr_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        redir_d    = 1'b0;
        redir_pc_d = redir_pc_q;
        unique case (state_q)
            IDLE: begin
                if (BE_i) begin
                    redir_d    = 1'b1;
                    redir_pc_d = PC_i;
                end
                // A load takes priority; a simultaneous store is dropped.
                if (DR_EN_i || DWR_EN_i) begin
                    state_d = REQ;
                    we_d    = !DR_EN_i;
                    addr_d  = address_i;
                    wdata_d = R2_i;
                    rd_d    = RD_i;
                    rwr_d   = RWR_EN_i;
                end else begin
                    rf_we_d    = RWR_EN_i && (RD_i != '0);
                    rf_waddr_d = RD_i;
                    rf_wdata_d = result_i;
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    state_d = we_q ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    state_d    = IDLE;
                    rf_we_d    = rwr_q && (rd_q != '0);
                    rf_waddr_d = rd_q;
                    rf_wdata_d = dmem_rdata_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            rwr_q      <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            rwr_q      <= rwr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            redir_q    <= redir_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    assign stall_o       = (state_q != IDLE);
    assign dmem_req_o    = (state_q == REQ);
    assign dmem_we_o     = we_q;
    assign dmem_addr_o   = addr_q;
    assign dmem_wdata_o  = wdata_q;
    assign rf_we_o       = rf_we_q;
    assign rf_waddr_o    = rf_waddr_q;
    assign rf_wdata_o    = rf_wdata_q;
    assign redirect_o    = redir_q;
    assign redirect_pc_o = redir_pc_q;

endmodule

// File: tb/tb_atomrvcore_mem_wb.sv
// Bench for atomrvcore_mem_wb: directed scenarios, then random instruction
// streams checked against a program-order reference model.
module tb_atomrvcore_mem_wb;

    localparam int NINSTR = 300;
    localparam int MAXCYC = 8000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] result, address, r2, pc;
    logic        dr_en, dwr_en, rwr_en, be;
    logic [4:0]  rd;
    logic        stall, req, we, gnt, rvalid;
    logic [31:0] addr_o, wdata_o, rdata;
    logic        rf_we, redir;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, redir_pc;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    atomrvcore_mem_wb dut (
        .clk_i(clk), .rst_i(rst),
        .result_i(result), .address_i(address),
        .DR_EN_i(dr_en), .DWR_EN_i(dwr_en),
        .R2_i(r2), .RD_i(rd), .RWR_EN_i(rwr_en),
        .PC_i(pc), .BE_i(be),
        .stall_o(stall),
        .dmem_req_o(req), .dmem_we_o(we),
        .dmem_addr_o(addr_o), .dmem_wdata_o(wdata_o),
        .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
        .dmem_rdata_i(rdata),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr),
        .rf_wdata_o(rf_wdata),
        .redirect_o(redir), .redirect_pc_o(redir_pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic nop();
        result = '0; address = '0; r2 = '0; pc = '0;
        dr_en = 0; dwr_en = 0; rwr_en = 0; be = 0; rd = '0;
    endtask

    // Reference state: program-order expectations and a word memory.
    logic [36:0] rf_q[$];
    logic [31:0] br_q[$];
    logic [64:0] mt_q[$];
    logic [31:0] mem[8];
    logic [31:0] refmem[8];
    logic [36:0] e_rf;
    logic [64:0] e_mt;
    logic [31:0] e_br;
    logic        pend_load, last_acc;
    logic [2:0]  pend_idx;
    int          issued, cyc, k;

    initial begin
        nop();
        rst = 1; gnt = 0; rvalid = 0; rdata = '0;
        tick(); tick();
        chk("rst_stall", stall, 0);
        chk("rst_req", req, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_redir", {redir, redir_pc}, 0);
        rst = 0;

        // ALU writeback
        rwr_en = 1; rd = 5; result = 32'h1234;
        tick();
        chk("alu_wb", {rf_we, rf_waddr, rf_wdata, stall},
            {1'b1, 5'd5, 32'h1234, 1'b0});
        nop();
        tick();
        chk("alu_one_shot", rf_we, 0);

        // x0 write suppressed
        rwr_en = 1; rd = 0; result = 32'hFFFF_FFFF;
        tick();
        chk("x0_no_we", rf_we, 0);
        nop();

        // Store with granted on the third request cycle
        dwr_en = 1; address = 32'h100; r2 = 32'hDEAD_BEEF;
        tick();
        nop();
        for (int i = 0; i < 3; i++) begin
            chk("st_req", {req, we, addr_o, wdata_o, stall, rf_we},
                {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b0});
            if (i == 2) gnt = 1;
            tick();
        end
        gnt = 0;
        chk("st_done", {req, stall, rf_we}, 0);

        // Load, immediate gnt, rvalid two cycles later, held ALU op behind it
        dr_en = 1; address = 32'h200; rd = 7; rwr_en = 1;
        tick();
        nop();
        rwr_en = 1; rd = 3; result = 32'h33;
        chk("ld_req", {req, we, addr_o, stall}, {1'b1, 1'b0, 32'h200, 1'b1});
        gnt = 1;
        tick();
        gnt = 0;
        chk("ld_wait", {req, stall, rf_we}, {1'b0, 1'b1, 1'b0});
        tick();
        chk("ld_wait2", {stall, rf_we}, {1'b1, 1'b0});
        rvalid = 1; rdata = 32'hCAFE_F00D;
        tick();
        rvalid = 0;
        chk("ld_wb", {rf_we, rf_waddr, rf_wdata, stall},
            {1'b1, 5'd7, 32'hCAFE_F00D, 1'b0});
        tick();
        chk("held_alu_wb", {rf_we, rf_waddr, rf_wdata},
            {1'b1, 5'd3, 32'h33});
        nop();
        tick();
        chk("held_alu_once", rf_we, 0);

        // Branch redirect, and none while stalled
        be = 1; pc = 32'h80;
        tick();
        chk("redir", {redir, redir_pc}, {1'b1, 32'h80});
        nop();
        tick();
        chk("redir_pulse", {redir, redir_pc}, {1'b0, 32'h80});
        dwr_en = 1; address = 32'h104; r2 = 32'h5;
        tick();
        nop();
        be = 1; pc = 32'h44;
        tick();
        chk("redir_stalled", redir, 0);
        gnt = 1;
        tick();
        gnt = 0;
        chk("redir_after_st", {redir, stall}, 0);
        tick();
        chk("redir_held", {redir, redir_pc}, {1'b1, 32'h44});
        nop();
        tick();

        // Reset while waiting for load data
        dr_en = 1; address = 32'h300; rd = 9; rwr_en = 1;
        tick();
        nop();
        gnt = 1;
        tick();
        gnt = 0;
        rst = 1;
        tick();
        rst = 0;
        rvalid = 1; rdata = 32'h1;
        chk("rst_mid_out", {stall, req, we, rf_we, rf_waddr, redir},
            0);
        chk("rst_mid_regs", {addr_o, wdata_o}, 0);
        tick();
        rvalid = 0;
        chk("rst_late_rvalid", {rf_we, stall}, 0);

        // Randomized stream against the program-order model
        for (int i = 0; i < 8; i++) begin
            mem[i] = $urandom;
            refmem[i] = mem[i];
        end
        pend_load = 0; pend_idx = '0;
        last_acc = 1; issued = 0; cyc = 0;
        while ((issued < NINSTR || rf_q.size() != 0 || br_q.size() != 0 ||
                mt_q.size() != 0 || stall) && cyc < MAXCYC) begin
            tick();
            cyc++;
            if (rf_we) begin
                if (rf_q.size() == 0) begin
                    chk("rf_spurious", rf_we, 0);
                end else begin
                    e_rf = rf_q.pop_front();
                    chk("rf_write", {rf_waddr, rf_wdata}, e_rf);
                end
            end
            if (redir) begin
                if (br_q.size() == 0) begin
                    chk("br_spurious", redir, 0);
                end else begin
                    e_br = br_q.pop_front();
                    chk("br_pc", redir_pc, e_br);
                end
            end
            // Memory responder
            if (pend_load && ($urandom % 3 == 0)) begin
                rvalid = 1; rdata = mem[pend_idx]; pend_load = 0;
            end else begin
                rvalid = !pend_load && ($urandom % 8 == 0);
                rdata = $urandom;
            end
            if (req && ($urandom % 3 == 0)) begin
                gnt = 1;
                if (mt_q.size() == 0) begin
                    chk("mem_spurious", req, 0);
                end else begin
                    e_mt = mt_q.pop_front();
                    chk("mem_we", we, e_mt[64]);
                    chk("mem_addr", addr_o, e_mt[63:32]);
                    if (e_mt[64]) begin
                        chk("mem_wdata", wdata_o, e_mt[31:0]);
                        mem[addr_o[4:2]] = wdata_o;
                    end else begin
                        pend_load = 1;
                        pend_idx = addr_o[4:2];
                    end
                end
            end else begin
                gnt = !req && ($urandom % 8 == 0);
            end
            // Upstream: new instruction once the previous one was taken
            if (last_acc) begin
                if (issued < NINSTR) begin
                    k = $urandom_range(0, 9);
                    dr_en  = (k < 3) || (k == 5);
                    dwr_en = (k == 3) || (k == 4) || (k == 5);
                    rwr_en = ($urandom % 4) != 0;
                    rd     = ($urandom % 6 == 0) ? 5'd0 : 5'($urandom);
                    be     = ($urandom % 4) == 0;
                    address = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
                    result = $urandom; r2 = $urandom; pc = $urandom;
                    issued++;
                end else begin
                    nop();
                end
            end
            last_acc = !stall;
            if (last_acc) begin
                if (be) br_q.push_back(pc);
                if (dr_en) begin
                    mt_q.push_back({1'b0, address, 32'h0});
                    if (rwr_en && rd != 0)
                        rf_q.push_back({rd, refmem[address[4:2]]});
                end else if (dwr_en) begin
                    mt_q.push_back({1'b1, address, r2});
                    refmem[address[4:2]] = r2;
                end else if (rwr_en && rd != 0) begin
                    rf_q.push_back({rd, result});
                end
            end
        end
        gnt = 0; rvalid = 0;
        chk("rnd_issued", issued, NINSTR);
        chk("rnd_drain_stall", stall, 0);
        chk("rnd_rf_left", rf_q.size(), 0);
        chk("rnd_br_left", br_q.size(), 0);
        chk("rnd_mem_left", mt_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
